adc_pair_sequencer: RTL and testbench

- Sequences the two I2C ADC reader instances (differential flying-cap channel 1, single-ended Vout channel 2) from one conversion request, normally the PWM carrier's ADC trigger.
- Captures both results coherently, clamps them to 12-bit magnitudes, and emits a single-cycle sample_valid_o. That pulse drives the controller's clock enable and the display buffers.
- Replaces the ad-hoc capture FSM in the top level and adds timeout recovery and overrun accounting.

---
 rtl/adc_seq_pkg.sv | 21 ++
 rtl/adc_seq_chan_capture.sv | 40 ++++
 rtl/adc_pair_sequencer.sv | 131 +++++++++++++
 tb/tb_adc_pair_sequencer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/adc_seq_pkg.sv
// Shared state type, widths and clamp helper for the ADC pair sequencer.
package adc_seq_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned VOLT_W_DEF = 12;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        CAPTURE,
        DONE
    } seqState_e;

    // Negative readings clamp to zero; otherwise keep the 12 magnitude MSBs.
    function automatic logic [VOLT_W_DEF-1:0] clampVolt(
        input logic [DATA_W_DEF-1:0] raw
    );
        return raw[DATA_W_DEF-1] ? '0 : raw[DATA_W_DEF-2:3];
    endfunction

endpackage

// File: rtl/adc_seq_chan_capture.sv
// One ADC channel: enable, done flag and coherent raw/volt capture.
module adc_seq_chan_capture
    import adc_seq_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned VOLT_W = VOLT_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start,
    input  logic              abort,
    input  logic              capture,
    input  logic              ready,
    input  logic [DATA_W-1:0] data,
    output logic              en,
    output logic              done,
    output logic [DATA_W-1:0] raw,
    output logic [VOLT_W-1:0] volt
);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            en   <= 1'b0;
            done <= 1'b0;
            raw  <= '0;
            volt <= '0;
        end else if (start) begin
            en   <= 1'b1;
            done <= 1'b0;
        end else if (abort) begin
            en <= 1'b0;
        end else if (capture && ready && !done) begin
            raw  <= data;
            volt <= clampVolt(data);
            done <= 1'b1;
            en   <= 1'b0;
        end
    end

endmodule

// File: rtl/adc_pair_sequencer.sv
// Sequences both ADC readers per trigger; ADC_SEQ_STATS_EN adds overrun/timeout counters.
module adc_pair_sequencer
    import adc_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 27000,
    parameter int unsigned DATA_W         = DATA_W_DEF,
    parameter int unsigned VOLT_W         = VOLT_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              trig_i,
    output logic              ch1_en_o,
    input  logic              ch1_ready_i,
    input  logic [DATA_W-1:0] ch1_data_i,
    output logic              ch2_en_o,
    input  logic              ch2_ready_i,
    input  logic [DATA_W-1:0] ch2_data_i,
    output logic              sample_valid_o,
    output logic [DATA_W-1:0] ch1_raw_o,
    output logic [DATA_W-1:0] ch2_raw_o,
    output logic [VOLT_W-1:0] ch1_volt_o,
    output logic [VOLT_W-1:0] ch2_volt_o,
    output logic              busy_o,
    output logic              timeout_o
`ifdef ADC_SEQ_STATS_EN
    ,
    output logic [15:0]       overrun_cnt_o,
    output logic [15:0]       timeout_cnt_o
`endif
);

    localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYCLES - 1);

    seqState_e stateQ, stateD;
    logic [TW-1:0] timerQ;
    logic timeoutQ;
    logic start, abort, inCapture, timing, timerHit;
    logic done1, done2;

    assign start     = (stateQ == IDLE) && trig_i;
    assign inCapture = (stateQ == CAPTURE);
    assign timing    = (stateQ == ARM) || inCapture;
    assign timerHit  = timing && (timerQ == TLIM);

    always_comb begin
        stateD = stateQ;
        abort  = 1'b0;
        unique case (stateQ)
            IDLE: if (trig_i) stateD = ARM;
            ARM: begin
                if (timerHit) begin
                    stateD = IDLE;
                    abort  = 1'b1;
                end else if (!ch1_ready_i && !ch2_ready_i) begin
                    stateD = CAPTURE;
                end
            end
            CAPTURE: begin
                if (done1 && done2) begin
                    stateD = DONE;
                end else if (timerHit) begin
                    stateD = IDLE;
                    abort  = 1'b1;
                end
            end
            DONE:    stateD = IDLE;
            default: stateD = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stateQ   <= IDLE;
            timerQ   <= '0;
            timeoutQ <= 1'b0;
        end else begin
            stateQ   <= stateD;
            timeoutQ <= abort;
            if (start) timerQ <= '0;
            else if (timing) timerQ <= timerQ + TW'(1);
        end
    end

    adc_seq_chan_capture #(.DATA_W(DATA_W), .VOLT_W(VOLT_W)) u_ch1 (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start   (start),
        .abort   (abort),
        .capture (inCapture),
        .ready   (ch1_ready_i),
        .data    (ch1_data_i),
        .en      (ch1_en_o),
        .done    (done1),
        .raw     (ch1_raw_o),
        .volt    (ch1_volt_o)
    );

    adc_seq_chan_capture #(.DATA_W(DATA_W), .VOLT_W(VOLT_W)) u_ch2 (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start   (start),
        .abort   (abort),
        .capture (inCapture),
        .ready   (ch2_ready_i),
        .data    (ch2_data_i),
        .en      (ch2_en_o),
        .done    (done2),
        .raw     (ch2_raw_o),
        .volt    (ch2_volt_o)
    );

    assign sample_valid_o = (stateQ == DONE);
    assign busy_o         = (stateQ != IDLE);
    assign timeout_o      = timeoutQ;

`ifdef ADC_SEQ_STATS_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            overrun_cnt_o <= '0;
            timeout_cnt_o <= '0;
        end else begin
            if (trig_i && stateQ != IDLE && overrun_cnt_o != 16'hFFFF)
                overrun_cnt_o <= overrun_cnt_o + 16'd1;
            if (abort && timeout_cnt_o != 16'hFFFF)
                timeout_cnt_o <= timeout_cnt_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_adc_pair_sequencer.sv
// Directed scenarios with a queued scoreboard checked by a negedge monitor.
module tb_adc_pair_sequencer;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        trig_i = 1'b0;
    logic        ch1_ready_i = 1'b1;
    logic        ch2_ready_i = 1'b1;
    logic [15:0] ch1_data_i = 16'h0;
    logic [15:0] ch2_data_i = 16'h0;
    logic        ch1_en_o, ch2_en_o, sample_valid_o, busy_o, timeout_o;
    logic [15:0] ch1_raw_o, ch2_raw_o;
    logic [11:0] ch1_volt_o, ch2_volt_o;
`ifdef ADC_SEQ_STATS_EN
    logic [15:0] overrun_cnt_o, timeout_cnt_o;
`endif

    adc_pair_sequencer #(.TIMEOUT_CYCLES(100)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .trig_i         (trig_i),
        .ch1_en_o       (ch1_en_o),
        .ch1_ready_i    (ch1_ready_i),
        .ch1_data_i     (ch1_data_i),
        .ch2_en_o       (ch2_en_o),
        .ch2_ready_i    (ch2_ready_i),
        .ch2_data_i     (ch2_data_i),
        .sample_valid_o (sample_valid_o),
        .ch1_raw_o      (ch1_raw_o),
        .ch2_raw_o      (ch2_raw_o),
        .ch1_volt_o     (ch1_volt_o),
        .ch2_volt_o     (ch2_volt_o),
        .busy_o         (busy_o),
        .timeout_o      (timeout_o)
`ifdef ADC_SEQ_STATS_EN
        ,
        .overrun_cnt_o  (overrun_cnt_o),
        .timeout_cnt_o  (timeout_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [15:0] r1;
        logic [15:0] r2;
        logic [11:0] v1;
        logic [11:0] v2;
    } exp_t;

    exp_t expQ[$];
    int   toQ[$];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        if (sample_valid_o) begin
            if (expQ.size() == 0) begin
                chk("unexpected_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                chk("valid_cycle", cyc, e.cyc);
                chk("ch1_raw", {16'h0, ch1_raw_o}, {16'h0, e.r1});
                chk("ch2_raw", {16'h0, ch2_raw_o}, {16'h0, e.r2});
                chk("ch1_volt", {20'h0, ch1_volt_o}, {20'h0, e.v1});
                chk("ch2_volt", {20'h0, ch2_volt_o}, {20'h0, e.v2});
            end
        end
        if (timeout_o) begin
            if (toQ.size() == 0) chk("unexpected_timeout", 32'd1, 32'd0);
            else chk("timeout_cycle", cyc, toQ.pop_front());
        end
    end

    task automatic chkIdleZero(input string name);
        chk({name, "_en"}, {30'h0, ch1_en_o, ch2_en_o}, 32'h0);
        chk({name, "_busy"}, {31'h0, busy_o}, 32'h0);
        chk({name, "_raw"}, {ch1_raw_o, ch2_raw_o}, 32'h0);
        chk({name, "_volt"}, {8'h0, ch1_volt_o, ch2_volt_o}, 32'h0);
        chk({name, "_pulses"}, {30'h0, sample_valid_o, timeout_o}, 32'h0);
    endtask

    initial begin
        // reset state
        goto(3);
        chkIdleZero("reset");
        rst_i = 1'b0;

        // normal conversion, stale-high readies until 14
        expQ.push_back('{57, 16'h3A98, 16'h1200, 12'h753, 12'h240});
        goto(10); trig_i = 1'b1;
        goto(11); trig_i = 1'b0;
        chk("arm_en", {30'h0, ch1_en_o, ch2_en_o}, 32'h3);
        chk("arm_busy", {31'h0, busy_o}, 32'h1);
        goto(14); ch1_ready_i = 1'b0; ch2_ready_i = 1'b0;
        goto(40); ch1_ready_i = 1'b1; ch1_data_i = 16'h3A98;
        goto(41);
        chk("ch1_en_fall", {30'h0, ch1_en_o, ch2_en_o}, 32'h1);
        goto(55); ch2_ready_i = 1'b1; ch2_data_i = 16'h1200;
        goto(56);
        chk("ch2_en_fall", {30'h0, ch1_en_o, ch2_en_o}, 32'h0);

        // negative clamp with simultaneous ready
        expQ.push_back('{82, 16'h8010, 16'h7FFF, 12'h000, 12'hFFF});
        goto(70); trig_i = 1'b1;
        goto(71); trig_i = 1'b0;
        goto(73); ch1_ready_i = 1'b0; ch2_ready_i = 1'b0;
        goto(80);
        ch1_ready_i = 1'b1; ch1_data_i = 16'h8010;
        ch2_ready_i = 1'b1; ch2_data_i = 16'h7FFF;
        goto(81);
        chk("simul_en_fall", {30'h0, ch1_en_o, ch2_en_o}, 32'h0);

        // stale ready held through ARM must not be captured
        expQ.push_back('{112, 16'h0800, 16'h0008, 12'h100, 12'h001});
        goto(100); trig_i = 1'b1; ch1_data_i = 16'h1111; ch2_data_i = 16'h2222;
        goto(101); trig_i = 1'b0;
        goto(104); ch1_ready_i = 1'b0;
        goto(106); ch2_ready_i = 1'b0;
        goto(109);
        chk("stale_en_held", {30'h0, ch1_en_o, ch2_en_o}, 32'h3);
        goto(110);
        ch1_ready_i = 1'b1; ch1_data_i = 16'h0800;
        ch2_ready_i = 1'b1; ch2_data_i = 16'h0008;

        // timeout: ARM entered at 131, ch2 never ready
        toQ.push_back(231);
        goto(130); trig_i = 1'b1;
        goto(131); trig_i = 1'b0;
        goto(133); ch1_ready_i = 1'b0; ch2_ready_i = 1'b0;
        goto(140); ch1_ready_i = 1'b1; ch1_data_i = 16'h2468;
        goto(230);
        chk("pre_timeout_busy", {31'h0, busy_o}, 32'h1);
        goto(231);
        chk("timeout_en", {30'h0, ch1_en_o, ch2_en_o}, 32'h0);
        chk("timeout_idle", {31'h0, busy_o}, 32'h0);
        chk("timeout_raw", {ch1_raw_o, ch2_raw_o}, {16'h2468, 16'h0008});
`ifdef ADC_SEQ_STATS_EN
        goto(232);
        chk("timeout_cnt", {16'h0, timeout_cnt_o}, 32'd1);
`endif

        // accepted after timeout, overruns in CAPTURE, then reset
        goto(240); trig_i = 1'b1;
        goto(241); trig_i = 1'b0;
        chk("retrig_en", {30'h0, ch1_en_o, ch2_en_o}, 32'h3);
        goto(243); ch1_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            goto(246 + 2 * i); trig_i = 1'b1;
            goto(247 + 2 * i); trig_i = 1'b0;
        end
        goto(252);
        chk("overrun_en", {30'h0, ch1_en_o, ch2_en_o}, 32'h3);
`ifdef ADC_SEQ_STATS_EN
        chk("overrun_cnt", {16'h0, overrun_cnt_o}, 32'd3);
`endif
        goto(255); rst_i = 1'b1;
        goto(256); rst_i = 1'b0;
        chkIdleZero("midreset");
`ifdef ADC_SEQ_STATS_EN
        chk("reset_cnts", {overrun_cnt_o, timeout_cnt_o}, 32'h0);
`endif

        // final conversion; trigger during DONE is dropped
        expQ.push_back('{267, 16'h0FFF, 16'hFFFF, 12'h1FF, 12'h000});
        goto(260); trig_i = 1'b1;
        goto(261); trig_i = 1'b0;
        goto(265);
        ch1_ready_i = 1'b1; ch1_data_i = 16'h0FFF;
        ch2_ready_i = 1'b1; ch2_data_i = 16'hFFFF;
        goto(267); trig_i = 1'b1;
        goto(268); trig_i = 1'b0;
        chk("done_trig_dropped", {31'h0, busy_o}, 32'h0);
`ifdef ADC_SEQ_STATS_EN
        chk("done_overrun_cnt", {16'h0, overrun_cnt_o}, 32'd1);
`endif

        goto(280);
        chk("valid_queue_empty", expQ.size(), 32'd0);
        chk("timeout_queue_empty", toQ.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
